// File: rtl/tp_pkg.sv
// Shared definitions for the test-point capture mux: FSM state encoding,
// heartbeat divider exponent and small decode helpers.
package tp_pkg;

  localparam logic [1:0] TP_STATE_IDLE  = 2'd0;
  localparam logic [1:0] TP_STATE_ARMED = 2'd1;
  localparam logic [1:0] TP_STATE_CAPT  = 2'd2;
  localparam logic [1:0] TP_STATE_DONE  = 2'd3;

  localparam int HB_EXP = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = TP_STATE_IDLE,
    ST_ARMED = TP_STATE_ARMED,
    ST_CAPT  = TP_STATE_CAPT,
    ST_DONE  = TP_STATE_DONE
  } tp_state_e;

  // The source select may only change while no capture is pending or running.
  function automatic logic tp_sel_loadable(input tp_state_e s);
    logic v;
    case (s)
      ST_IDLE:  v = 1'b1;
      ST_DONE:  v = 1'b1;
      ST_ARMED: v = 1'b0;
      ST_CAPT:  v = 1'b0;
      default:  v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/tp_capture_ram.sv
// Capture buffer: simple dual-port DEPTH x TPW memory, one write port and one
// registered read port whose output holds between reads.
module tp_capture_ram #(
  parameter int DEPTH = 16,
  parameter int TPW   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [TPW-1:0]           i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [TPW-1:0]           o_rdata
);

  logic [TPW-1:0] r_mem [DEPTH];
  logic [TPW-1:0] r_rdata;

  // Storage array; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port, cleared by reset and held when no read is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= {TPW{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tp_capture_mux.sv
// Test-point source mux with triggered capture buffer and readout.
// Optional macro TP_HEARTBEAT_EN puts a slow heartbeat on TP_OUT[TPW-1].
module tp_capture_mux
  import tp_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int TPW   = 16,
  parameter int DEPTH = 16
) (
  input  logic                    CLK40,
  input  logic                    RST,
  input  logic [NSRC*TPW-1:0]     SRC_DATA,
  input  logic [$clog2(NSRC)-1:0] SEL,
  input  logic                    ARM,
  input  logic [TPW-1:0]          TRIG_MASK,
  input  logic [TPW-1:0]          TRIG_VAL,
  input  logic                    RD_REQ,
  output logic [TPW-1:0]          TP_OUT,
  output logic [TPW-1:0]          RD_DATA,
  output logic                    RD_VLD,
  output logic [1:0]              STATE
);

  localparam int SELW = $clog2(NSRC);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  tp_state_e      r_state;
  logic [SELW-1:0] r_sel;
  logic [TPW-1:0] r_tp_sel;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic           r_rd_vld;

  tp_state_e      w_state_nxt;
  logic [AW-1:0]  w_wr_ptr_nxt;
  logic [AW-1:0]  w_rd_ptr_nxt;
  logic [AW-1:0]  w_waddr;
  logic           w_we;
  logic           w_re;
  logic           w_match;

  // Source select register, frozen while a capture is pending or running.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_sel <= {SELW{1'b0}};
    end else if (tp_sel_loadable(r_state)) begin
      r_sel <= SEL;
    end else begin
      r_sel <= r_sel;
    end
  end

  // Selected bus register; this unmodified copy feeds trigger and capture.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_tp_sel <= {TPW{1'b0}};
    end else begin
      r_tp_sel <= SRC_DATA[r_sel*TPW +: TPW];
    end
  end

  assign w_match = (((r_tp_sel ^ TRIG_VAL) & TRIG_MASK) == {TPW{1'b0}});

  // Next-state, buffer write/read strobes and pointer updates.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_waddr      = r_wr_ptr;
    w_we         = 1'b0;
    w_re         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ARM) begin
          w_state_nxt  = ST_ARMED;
          w_wr_ptr_nxt = {AW{1'b0}};
          w_rd_ptr_nxt = {AW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (w_match) begin
          w_we         = 1'b1;
          w_waddr      = {AW{1'b0}};
          w_wr_ptr_nxt = AW'(1);
          w_state_nxt  = ST_CAPT;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_CAPT: begin
        w_we = 1'b1;
        if (r_wr_ptr == LAST_ADDR) begin
          w_wr_ptr_nxt = {AW{1'b0}};
          w_state_nxt  = ST_DONE;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + AW'(1);
          w_state_nxt  = ST_CAPT;
        end
      end
      ST_DONE: begin
        // ARM takes priority over a simultaneous read request.
        if (ARM) begin
          w_rd_ptr_nxt = {AW{1'b0}};
          w_wr_ptr_nxt = {AW{1'b0}};
          w_state_nxt  = ST_ARMED;
        end else if (RD_REQ) begin
          w_re         = 1'b1;
          w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_wr_ptr_nxt = {AW{1'b0}};
        w_rd_ptr_nxt = {AW{1'b0}};
      end
    endcase
  end

  // FSM state, pointers and read-valid qualifier.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_rd_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_rd_vld <= w_re;
    end
  end

  tp_capture_ram #(
    .DEPTH (DEPTH),
    .TPW   (TPW)
  ) u_ram (
    .i_clk   (CLK40),
    .i_rst   (RST),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_tp_sel),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (RD_DATA)
  );

  assign RD_VLD = r_rd_vld;
  assign STATE  = r_state;

`ifdef TP_HEARTBEAT_EN
  logic [HB_EXP-1:0] r_hb_cnt;
  logic              r_hb;

  // Free-running divider; the heartbeat flips each time it wraps.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_hb_cnt <= {HB_EXP{1'b0}};
      r_hb     <= 1'b0;
    end else begin
      r_hb_cnt <= r_hb_cnt + HB_EXP'(1);
      if (&r_hb_cnt) begin
        r_hb <= ~r_hb;
      end else begin
        r_hb <= r_hb;
      end
    end
  end

  assign TP_OUT = {r_hb, r_tp_sel[TPW-2:0]};
`else
  assign TP_OUT = r_tp_sel;
`endif

endmodule

// File: tb/tb_tp_capture_mux.sv
// Directed self-checking bench for tp_capture_mux (NSRC=4, TPW=16, DEPTH=8).
module tb_tp_capture_mux;

  localparam int NSRC  = 4;
  localparam int TPW   = 16;
  localparam int DEPTH = 8;

  logic            CLK40 = 1'b0;
  logic            RST;
  logic [TPW-1:0]  src [NSRC];
  logic [NSRC*TPW-1:0] SRC_DATA;
  logic [1:0]      SEL;
  logic            ARM;
  logic [TPW-1:0]  TRIG_MASK;
  logic [TPW-1:0]  TRIG_VAL;
  logic            RD_REQ;
  logic [TPW-1:0]  TP_OUT;
  logic [TPW-1:0]  RD_DATA;
  logic            RD_VLD;
  logic [1:0]      STATE;

  int vectors = 0;
  int miscompares = 0;

  assign SRC_DATA = {src[3], src[2], src[1], src[0]};

  always #5 CLK40 = ~CLK40;

  tp_capture_mux #(
    .NSRC  (NSRC),
    .TPW   (TPW),
    .DEPTH (DEPTH)
  ) dut (
    .CLK40     (CLK40),
    .RST       (RST),
    .SRC_DATA  (SRC_DATA),
    .SEL       (SEL),
    .ARM       (ARM),
    .TRIG_MASK (TRIG_MASK),
    .TRIG_VAL  (TRIG_VAL),
    .RD_REQ    (RD_REQ),
    .TP_OUT    (TP_OUT),
    .RD_DATA   (RD_DATA),
    .RD_VLD    (RD_VLD),
    .STATE     (STATE)
  );

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int capt_cnt;

    RST = 1'b1; SEL = 2'd0; ARM = 1'b0; RD_REQ = 1'b0;
    TRIG_MASK = 16'hFFFF; TRIG_VAL = 16'h0000;
    src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h0000; src[3] = 16'h4444;
    tick(); tick();
    chk("rst_state", {30'd0, STATE}, 32'd0);
    chk("rst_tp_out", {16'd0, TP_OUT}, 32'd0);
    chk("rst_rd_vld", {31'd0, RD_VLD}, 32'd0);
    chk("rst_rd_data", {16'd0, RD_DATA}, 32'd0);

    // Select source 2; first edge still uses the reset select of 0.
    RST = 1'b0; SEL = 2'd2; src[2] = 16'hA5A5; RD_REQ = 1'b1;
    tick();
    RD_REQ = 1'b0;
    chk("sel_q_reset_zero", {16'd0, TP_OUT}, 32'h0000_1111);
    chk("rdreq_idle_ignored", {31'd0, RD_VLD}, 32'd0);
    tick();
    chk("sel2_tp_out", {16'd0, TP_OUT}, 32'h0000_A5A5);

    // Arm with a non-matching trigger, then try to change SEL while ARMED.
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    chk("armed_state", {30'd0, STATE}, 32'd1);
    SEL = 2'd1; src[1] = 16'h5A5A;
    tick(); tick();
    chk("sel_hold_armed", {16'd0, TP_OUT}, 32'h0000_A5A5);
    chk("armed_no_match", {30'd0, STATE}, 32'd1);
    SEL = 2'd2;

    // Ramp source 2 and trigger on low byte 0x42.
    TRIG_MASK = 16'h00FF; TRIG_VAL = 16'h0042;
    capt_cnt = 0;
    k = 0;
    while (k < 40) begin
      src[2] = 16'h0040 + 16'(k);
      tick();
      if (STATE == 2'd2) capt_cnt++;
      if (STATE == 2'd3) break;
      k++;
    end
    chk("ramp_done_step", k, 32'd10);
    chk("ramp_capt_cycles", capt_cnt, 32'd7);

    // Nine reads, each followed by an idle cycle; ninth wraps to word 0.
    for (int i = 0; i < 9; i++) begin
      RD_REQ = 1'b1;
      tick();
      RD_REQ = 1'b0;
      chk("read_vld", {31'd0, RD_VLD}, 32'd1);
      chk("read_data", {16'd0, RD_DATA}, 32'h0042 + 32'(i % 8));
      tick();
      chk("read_idle_vld", {31'd0, RD_VLD}, 32'd0);
      chk("read_idle_hold", {16'd0, RD_DATA}, 32'h0042 + 32'(i % 8));
    end

    // ARM and RD_REQ together in DONE; all-zero mask fires on first ARMED cycle.
    TRIG_MASK = 16'h0000;
    src[2] = 16'h0100;
    ARM = 1'b1; RD_REQ = 1'b1;
    tick();
    ARM = 1'b0; RD_REQ = 1'b0;
    chk("arm_wins_state", {30'd0, STATE}, 32'd1);
    chk("arm_wins_vld", {31'd0, RD_VLD}, 32'd0);
    src[2] = 16'h0101;
    tick();
    chk("mask0_one_armed", {30'd0, STATE}, 32'd2);

    // ARM pulsed during CAPT must not disturb the 8-word capture.
    k = 2;
    while (k < 40) begin
      src[2] = 16'h0100 + 16'(k);
      ARM = (k == 2);
      tick();
      ARM = 1'b0;
      if (STATE == 2'd3) break;
      k++;
    end
    chk("arm_in_capt_done_step", k, 32'd8);
    RD_REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("burst_read_vld", {31'd0, RD_VLD}, 32'd1);
      chk("burst_read_data", {16'd0, RD_DATA}, 32'h0100 + 32'(i));
    end
    RD_REQ = 1'b0;
    tick();

    // Reset on the 4th CAPT cycle abandons the capture.
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    chk("rearm_state", {30'd0, STATE}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("capt4_state", {30'd0, STATE}, 32'd2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_state", {30'd0, STATE}, 32'd0);
    chk("midrst_tp_out", {16'd0, TP_OUT}, 32'd0);
    chk("midrst_rd_vld", {31'd0, RD_VLD}, 32'd0);
    RD_REQ = 1'b1;
    tick();
    chk("postrst_rd_vld", {31'd0, RD_VLD}, 32'd0);
    RD_REQ = 1'b0;
    tick();
    chk("postrst_rd_vld2", {31'd0, RD_VLD}, 32'd0);
    chk("postrst_state", {30'd0, STATE}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tp_capture_mux.md
TP_CAPTURE_MUX -- requirements
Module: tp_capture_mux

Interface
REQ-001 SHALL provide parameter NSRC, default 4: number of selectable source buses (2..16).
REQ-002 SHALL provide parameter TPW, default 16: width of each source bus and of the test-point output.
REQ-003 SHALL provide parameter DEPTH, default 16: capture buffer depth (power of two, 4..256).
REQ-004 SHALL provide port CLK40  input  1: the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL provide port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL provide port SRC_DATA  input  NSRC*TPW: concatenated source buses; source k occupies bits [k*TPW +: TPW].
REQ-007 SHALL provide port SEL  input  clog2(NSRC): source select request.
REQ-008 SHALL provide port ARM  input  1: single-cycle arm or re-arm request.
REQ-009 SHALL provide ports TRIG_MASK and TRIG_VAL  input  TPW each: trigger compare mask and value.
REQ-010 SHALL provide port RD_REQ  input  1: capture-buffer read strobe.
REQ-011 SHALL provide port TP_OUT  output  TPW: registered selected bus, which drives the test points.
REQ-012 SHALL provide port RD_DATA  output  TPW and port RD_VLD  output  1: readout word and its qualifier.
REQ-013 SHALL provide port STATE  output  2: FSM state encoded as IDLE=0, ARMED=1, CAPT=2, DONE=3.

Function
REQ-014 SHALL load SEL into sel_q only while in IDLE or DONE; sel_q SHALL hold in ARMED and CAPT.
REQ-015 SHALL register TP_OUT from SRC_DATA[sel_q] with exactly 1-cycle latency, in every state.
REQ-016 SHALL form match = ((TP_OUT ^ TRIG_VAL) & TRIG_MASK) == 0, evaluated on the registered TP_OUT.
REQ-017 FSM, IDLE: go to ARMED on ARM.
REQ-018 FSM, ARMED: on match, write the current TP_OUT to buffer address 0 and go to CAPT; while there is no match, stay in ARMED.
REQ-019 FSM, CAPT: write TP_OUT on every cycle at consecutive addresses; go to DONE on the cycle that writes address DEPTH-1. Exactly DEPTH words SHALL be written per capture.
REQ-020 FSM, DONE: on ARM, clear the read pointer and go to ARMED.
REQ-021 SHALL ignore ARM while in ARMED or CAPT; a capture in progress SHALL never be aborted by ARM.
REQ-022 If TRIG_MASK is all zeros, the trigger SHALL fire on the first ARMED cycle.
REQ-023 Readout in DONE: each RD_REQ SHALL give RD_DATA = buf[rd_ptr] with RD_VLD=1 on the next cycle, then increment rd_ptr, wrapping from DEPTH-1 to 0.
REQ-024 RD_REQ outside DONE SHALL be ignored; RD_VLD SHALL be 0 on the following cycle.
REQ-025 If ARM and RD_REQ are both asserted in DONE, ARM SHALL win; no read occurs and RD_VLD=0 on the next cycle.
REQ-026 RD_DATA SHALL hold its last value when RD_VLD=0.

Reset
REQ-027 While RST=1: STATE=IDLE, sel_q=0, TP_OUT=0, RD_DATA=0, RD_VLD=0, write and read pointers=0.
REQ-028 RST asserted mid-capture or mid-readout SHALL abandon the operation; buffer contents are undefined afterwards and no RD_VLD SHALL follow.

Configuration
REQ-029 Macro TP_HEARTBEAT_EN, when defined: TP_OUT[TPW-1] SHALL carry a heartbeat that toggles every 2^20 CLK40 cycles, from a counter reset to 0 by RST. Triggering and capture SHALL still use the unmodified selected bit.
REQ-030 Without TP_HEARTBEAT_EN: TP_OUT SHALL be exactly the selected bus, and no heartbeat counter SHALL exist.

Structure
REQ-031 A shared package tp_pkg SHALL hold the FSM state enumeration, the STATE encodings and the heartbeat divider exponent (20).
REQ-032 One sub-module, tp_capture_ram (simple dual-port, 1 write and 1 registered read, DEPTH x TPW), SHALL hold the buffer; all other logic is in tp_capture_mux.

Verification (NSRC=4, TPW=16, DEPTH=8)
REQ-033 SEL=2, source2=16'hA5A5 -> TP_OUT=16'hA5A5 one cycle later; changing SEL in ARMED -> TP_OUT keeps source 2.
REQ-034 ARM, TRIG_MASK=16'h00FF, TRIG_VAL=16'h0042, source ramps 0x0040,0x0041,... -> capture starts at word 0x0042; DONE after 8 writes; reads return 0x0042..0x0049, RD_VLD 1 cycle after each RD_REQ.
REQ-035 Nine RD_REQ pulses in DONE -> ninth read returns 0x0042 again (pointer wrap).
REQ-036 TRIG_MASK=0 -> ARMED lasts exactly 1 cycle; ARM pulsed during CAPT -> ignored, still exactly 8 words written.
REQ-037 RST asserted on the 4th CAPT cycle -> next cycle STATE=IDLE, TP_OUT=0, RD_VLD=0; RD_REQ then -> RD_VLD remains 0.
REQ-038 ARM and RD_REQ together in DONE -> STATE=ARMED next cycle, RD_VLD=0; with TP_HEARTBEAT_EN, TP_OUT[15] toggles at cycle 2^20 after RST.
